data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 107 ++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between a processor and a responder.
// Ports: req/we/addr/wdata from master; rdata/ack/busy/err from slave.
interface data_mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with wait states and one-cycle ack pulse.
// Ports: clk, reset (sync, active-low), bus (slave: req/we/addr/wdata
// in, rdata/ack/busy/err out). Option: DATA_MEM_ALIGN_CHECK_EN flags
// accesses with addr[1:0] != 0 via err and suppresses them.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int WORDS = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t st;
  state_t st_n;

  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-3:0] widx_q;
  logic [31:0]       wdata_q;
  logic              mis;
  logic              take;

  logic [31:0] mem [WORDS];

  assign take = (st == IDLE) && bus.req;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (take) mis_q <= |bus.addr[1:0];
  end

  assign mis = mis_q;
`else
  wire unused_lsb = &{1'b0, bus.addr[1:0]};

  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) st <= IDLE;
    else        st <= st_n;
  end

  always_comb begin
    st_n = st;
    case (st)
      IDLE: begin
        if (bus.req) st_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        // cnt <= 1 guards against a stuck zero count
        if (cnt <= 4'd1) st_n = RESP;
      end
      RESP:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)         cnt <= '0;
    else if (take)      cnt <= 4'(WAIT_CYCLES);
    else if (st == WAIT) cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (take) begin
      we_q    <= bus.we;
      widx_q  <= bus.addr[ADDR_W-1:2];
      wdata_q <= bus.wdata;
    end
  end

  // No reset on the array; reset only blocks the RESP-cycle write
  always_ff @(posedge clk) begin
    if (reset && st == RESP && we_q && !mis)
      mem[widx_q] <= wdata_q;
  end

  always_comb begin
    bus.ack   = 1'b0;
    bus.busy  = 1'b0;
    bus.err   = 1'b0;
    bus.rdata = '0;
    unique case (1'b1)
      (st == RESP): begin
        bus.ack  = 1'b1;
        bus.busy = 1'b1;
        bus.err  = mis;
        if (!we_q && !mis) bus.rdata = mem[widx_q];
      end
      (st == WAIT): bus.busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (WAIT_CYCLES 2 and 0).
// Drives on negedge, samples on negedge after the active edge.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mm [2][64];
  bit          kn [2][64];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(8)) b2 ();
  data_mem_responder_if #(.ADDR_W(8)) b0 ();

  assign b2.req   = req & ~sel;
  assign b2.we    = we;
  assign b2.addr  = addr;
  assign b2.wdata = wdata;
  assign b0.req   = req & sel;
  assign b0.we    = we;
  assign b0.addr  = addr;
  assign b0.wdata = wdata;

  data_mem_responder #(
    .ADDR_W(8),
    .WAIT_CYCLES(2)
  ) u_w2 (
    .clk(clk),
    .reset(reset),
    .bus(b2)
  );

  data_mem_responder #(
    .ADDR_W(8),
    .WAIT_CYCLES(0)
  ) u_w0 (
    .clk(clk),
    .reset(reset),
    .bus(b0)
  );

  wire        ack_o   = sel ? b0.ack   : b2.ack;
  wire        busy_o  = sel ? b0.busy  : b2.busy;
  wire        err_o   = sel ? b0.err   : b2.err;
  wire [31:0] rdata_o = sel ? b0.rdata : b2.rdata;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ack"},   ack_o,   0);
    chk({tag, "_busy"},  busy_o,  0);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_err"},   err_o,   0);
  endtask

  // One transaction; inputs are scrambled right after capture.
  task automatic xact(
    input bit          s,
    input bit          w,
    input logic [7:0]  a,
    input logic [31:0] d
  );
    int n;
    int wc;
    int i;
    bit mis;
    wc  = s ? 0 : 2;
    i   = int'(a[7:2]);
    mis = ALIGN && (a[1:0] != 2'b00);
    @(negedge clk);
    sel = s; req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'($urandom);
    addr  = 8'($urandom);
    wdata = $urandom;
    while (ack_o !== 1'b1 && n < 40) begin
      chk("busy_wait", busy_o, 1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(wc + 1));
    chk("busy_ack", busy_o, 1);
    chk("err", err_o, mis);
    if (w || mis)
      chk("rdata_st", rdata_o, 0);
    else if (kn[s][i])
      chk("rdata_ld", rdata_o, mm[s][i]);
    if (w && !mis) begin
      mm[s][i] = d;
      kn[s][i] = 1'b1;
    end
    @(negedge clk);
    idle_chk("post");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          s;
    bit          w;
    logic [7:0]  a;
    int          k;
    reset = 1'b0; sel = 1'b0; req = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("rst");
    reset = 1'b1;

    xact(0, 1, 8'h30, 32'h1111_1111);

    // reset held with a pending store request
    @(negedge clk);
    reset = 1'b0; req = 1'b1; we = 1'b1;
    addr = 8'h30; wdata = 32'hBAD0_BAD0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rreq_ack",   ack_o,   0);
      chk("rreq_busy",  busy_o,  0);
      chk("rreq_rdata", rdata_o, 0);
    end
    req = 1'b0; reset = 1'b1;
    xact(0, 0, 8'h30, 0);

    xact(0, 1, 8'h10, 32'hDEAD_BEEF);
    xact(0, 0, 8'h10, 0);
    chk("st_ld_model", mm[0][4], 32'hDEAD_BEEF);

    xact(0, 1, 8'h04, 32'd1);
    xact(0, 1, 8'h08, 32'd2);
    xact(0, 1, 8'h0C, 32'd3);
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b0; addr = 8'h04;
    k = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ack", ack_o, 32'(e % 4 == 3));
      if (e % 4 != 0) chk("b2b_busy", busy_o, 1);
      if (e % 4 == 3) begin
        chk("b2b_rdata", rdata_o, 32'(k + 1));
        k++;
        addr = 8'(4 * (k + 1));
        if (k == 3) req = 1'b0;
      end
    end

    // reset during WAIT of a store
    xact(0, 1, 8'h20, 32'hCAFE_F00D);
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b1;
    addr = 8'h20; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy_o, 1);
    reset = 1'b0; req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_chk("mid_rst");
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("mid_noack", ack_o, 0);
    end
    xact(0, 0, 8'h20, 0);

    xact(0, 1, 8'h21, 32'h0BAD_F00D);
    xact(0, 0, 8'h20, 0);

    xact(1, 1, 8'h40, 32'h55AA_55AA);
    xact(1, 0, 8'h40, 0);
    xact(1, 0, 8'h10, 0);

    repeat (60) begin
      s = ($urandom_range(0, 3) == 0);
      w = 1'($urandom);
      a = {2'b00, 4'($urandom), 2'($urandom)};
      xact(s, w, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
